// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-bit-pointer register space; register storage is external,
// reached through a write-strobe / combinational-read bus. SCL is never stretched.
module i2c_target_regs #(
    parameter logic [6:0]  DEV_ADDR   = 7'h50,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic       reg_wr_valid,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic [7:0] reg_rd_addr,
    input  logic [7:0] reg_rd_data,
    output logic       reg_rd_strobe,
    output logic       busy
);

    localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_A,
        PTR,
        ACK_P,
        WDATA,
        ACK_W,
        RDATA,
        MACK,
        WAIT_STOP
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic [3:0] scl_cnt, sda_cnt;
    logic       scl_f, sda_f, scl_p, sda_p;
    logic       start_evt, stop_evt, scl_rise, scl_fall;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;
    logic       sda_t_q, sda_t_d;
    logic       busy_q, busy_d;
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rd_strobe;
    logic [7:0] shift_in;

    // A filtered level only flips after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FILT_MAX) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FILT_MAX) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    assign start_evt = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_evt  = scl_f & scl_p & ~sda_p & sda_f;
    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            sda_t_q    <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            sda_t_q    <= sda_t_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign shift_in = {shreg_q[6:0], sda_f};

    // ACK states see two SCL falls: the first (sda_t still released) drives the ACK,
    // the second ends the ACK clock. The read shifter is held pre-shifted so that
    // shreg_q[7] is always the next bit to drive.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        sda_t_d    = sda_t_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_strobe  = 1'b0;

        if (start_evt) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            sda_t_d   = 1'b1;
        end else if (stop_evt) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            sda_t_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shreg_q[6:0] == DEV_ADDR) begin
                                state_d = ACK_A;
                                busy_d  = 1'b1;
                                rw_d    = sda_f;
                            end else begin
                                state_d = WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ACK_A: begin
                    if (scl_fall) begin
                        if (sda_t_q) begin
                            sda_t_d = 1'b0;
                        end else if (rw_q) begin
                            rd_strobe = 1'b1;
                            sda_t_d   = reg_rd_data[7];
                            shreg_d   = {reg_rd_data[6:0], 1'b1};
                            state_d   = RDATA;
                        end else begin
                            sda_t_d = 1'b1;
                            state_d = PTR;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shreg_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_d   = shift_in;
                            state_d = ACK_P;
                        end
                    end
                end
                ACK_P, ACK_W: begin
                    if (scl_fall) begin
                        if (sda_t_q) begin
                            sda_t_d = 1'b0;
                        end else begin
                            sda_t_d = 1'b1;
                            state_d = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shreg_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = shift_in;
                            ptr_d      = ptr_q + 8'd1;
                            state_d    = ACK_W;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = MACK;
                            phase_d = 1'b0;
                        end
                    end else if (scl_fall) begin
                        sda_t_d = shreg_q[7];
                        shreg_d = {shreg_q[6:0], 1'b1};
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr_q + 8'd1;
                        if (sda_f) begin
                            state_d = WAIT_STOP;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (phase_q) begin
                            rd_strobe = 1'b1;
                            sda_t_d   = reg_rd_data[7];
                            shreg_d   = {reg_rd_data[6:0], 1'b1};
                            phase_d   = 1'b0;
                            state_d   = RDATA;
                        end else begin
                            sda_t_d = 1'b1;
                        end
                    end
                end
                WAIT_STOP: sda_t_d = 1'b1;
                default: begin
                    state_d = IDLE;
                    sda_t_d = 1'b1;
                end
            endcase
        end
    end

    assign sda_o         = 1'b0;
    assign sda_t         = sda_t_q;
    assign busy          = busy_q;
    assign reg_wr_valid  = wr_valid_q;
    assign reg_wr_addr   = wr_addr_q;
    assign reg_wr_data   = wr_data_q;
    assign reg_rd_addr   = ptr_q;
    assign reg_rd_strobe = rd_strobe;

endmodule
